pic_buffer: RTL and testbench
=============================

PIC_BUFFER -- requirements
Module: pic_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, address width; depth per bank DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_BANKS, default 2, legal values 1 or 2 (single or double buffer).
REQ-004 SHALL have parameter CLR_VALUE, default 0, DATA_W-bit word written by the clear engine.
REQ-005 SHALL have port sys_clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, write strobe into the write bank.
REQ-008 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have port rd_en, input, 1, read request from the display bank.
REQ-011 SHALL have port rd_addr, input, ADDR_W, read address.
REQ-012 SHALL have port rd_data, output, DATA_W, registered read data.
REQ-013 SHALL have port rd_valid, output, 1, rd_data is valid this cycle.
REQ-014 SHALL have port clr_start, input, 1, one-cycle pulse that starts a fill of the write bank.
REQ-015 SHALL have port busy, output, 1, clear engine active.
REQ-016 SHALL have port swap_req, input, 1, one-cycle pulse that requests a bank swap.
REQ-017 SHALL have port frame_sync, input, 1, one-cycle frame boundary pulse from the LCD timing block.
REQ-018 SHALL have port swap_pending, output, 1, swap requested but not yet executed.
REQ-019 SHALL have port bank_sel, output, 1, current display bank; the write bank is !bank_sel when NUM_BANKS=2.

Function
REQ-020 Storage SHALL be NUM_BANKS x DEPTH words of DATA_W bits, inferable as block RAM; contents SHALL NOT be reset.
REQ-021 Read: rd_en in cycle N SHALL give rd_data = word[display bank][rd_addr] and rd_valid=1 in cycle N+1; rd_valid=0 in any cycle that follows a cycle without rd_en.
REQ-022 rd_data SHALL hold its last value while rd_valid=0.
REQ-023 Write: wr_en with busy=0 SHALL update word[write bank][wr_addr] at that edge.
REQ-024 Same-address read and write in one cycle, same bank (NUM_BANKS=1), SHALL return the old data (read-first).
REQ-025 Clear FSM states: IDLE, FILL. IDLE->FILL on clr_start; busy=1 from the next cycle.
REQ-026 In FILL, the engine SHALL write CLR_VALUE to the write bank at addresses 0,1,...,DEPTH-1, one per cycle, for exactly DEPTH cycles.
REQ-027 FILL->IDLE after the address DEPTH-1 write; busy=0 in the following cycle; the address counter SHALL wrap to 0.
REQ-028 clr_start while busy=1 SHALL be ignored (no restart, no extension).
REQ-029 wr_en while busy=1 SHALL be dropped, with no memory update.
REQ-030 Reads SHALL continue unaffected during FILL.
REQ-031 Swap: swap_req SHALL set swap_pending=1 in the next cycle; repeated swap_req while pending SHALL merge into a single swap.
REQ-032 When swap_pending=1, frame_sync=1 and busy=0 coincide, bank_sel SHALL toggle at that edge and swap_pending SHALL clear.
REQ-033 frame_sync while busy=1 SHALL leave the swap pending until the first frame_sync with busy=0.
REQ-034 swap_req and a swap-executing frame_sync in the same cycle SHALL execute the swap and leave swap_pending=1 for the new request.
REQ-035 A read issued in the swap cycle SHALL use the pre-swap bank.
REQ-036 With NUM_BANKS=1, bank_sel SHALL be constant 0, swap_pending constant 0, and reads and writes SHALL share bank 0.

Reset
REQ-037 With sys_rst=1 at an edge, the block SHALL set rd_data=0, rd_valid=0, busy=0 (FSM IDLE, address counter 0), swap_pending=0 and bank_sel=0.
REQ-038 Reset asserted during FILL SHALL abort the fill; words already written SHALL keep CLR_VALUE, and the rest SHALL be unchanged.
REQ-039 Inputs SHALL be ignored while sys_rst=1.

Verification
REQ-040 Write 16'hB93C to addr 5 of bank 1, swap via swap_req and then frame_sync, rd_en addr 5 -> rd_data=16'hB93C with rd_valid=1 exactly one cycle after rd_en.
REQ-041 clr_start with CLR_VALUE=16'h0000 and ADDR_W=9 -> busy high for exactly 512 cycles, with wr_en dropped throughout; after the swap, all 512 reads return 0.
REQ-042 swap_req, then frame_sync during FILL -> bank_sel unchanged and swap_pending=1; the next frame_sync after busy=0 -> bank_sel toggles and swap_pending=0.
REQ-043 NUM_BANKS=1: write 16'h1234 and read addr 7 in the same cycle, old value 16'hAAAA -> 16'hAAAA; the next read -> 16'h1234.
REQ-044 sys_rst asserted at fill cycle 100 -> busy=0 next cycle; addrs 0..99 = CLR_VALUE, addrs 100..511 unchanged.
REQ-045 swap_req coincident with an executing frame_sync -> bank_sel toggles and swap_pending stays 1; the next frame_sync toggles bank_sel back.

Source files
------------

// File: rtl/pic_buffer.sv
// pic_buffer: single/double-banked pixel frame buffer with a registered read port,
// a fill-with-constant clear engine and a frame-synchronised bank swap.
module pic_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int NUM_BANKS = 2,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  output logic              busy,
  input  logic              swap_req,
  input  logic              frame_sync,
  output logic              swap_pending,
  output logic              bank_sel
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int AW = ADDR_W + NUM_BANKS - 1;
  localparam bit DUAL = (NUM_BANKS == 2);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [NUM_BANKS*DEPTH];
  logic wb, we, swap;
  logic [AW-1:0] wi, ri;
  logic [DATA_W-1:0] wd;
  // The clear engine owns the write port while busy; host writes are dropped.
  always_comb begin
    wb = DUAL ? ~bank_sel : 1'b0;
    we = !sys_rst && (busy || wr_en);
    wi = AW'({wb, busy ? cnt : wr_addr});
    ri = AW'({bank_sel, rd_addr});
    wd = busy ? CLR_VALUE : wr_data;
    swap = DUAL && swap_pending && frame_sync && !busy;
  end
  always_ff @(posedge sys_clk)
    if (we) mem[wi] <= wd;
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[ri];
    end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state <= IDLE;
      busy <= 1'b0;
      cnt <= '0;
      swap_pending <= 1'b0;
      bank_sel <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (clr_start) begin
          state <= FILL;
          busy <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= IDLE;
          busy <= 1'b0;
        end
      end
      // A request arriving with the executing frame_sync re-arms for the next frame.
      swap_pending <= DUAL && (swap_req || (swap_pending && !swap));
      bank_sel <= bank_sel ^ swap;
    end
endmodule

// File: tb/tb_pic_buffer.sv
// tb_pic_buffer: directed checks of pic_buffer, double-bank (ADDR_W=9) and single-bank (ADDR_W=4).
module tb_pic_buffer;
  logic clk = 1'b0;
  logic rst;
  logic wr_en, rd_en, clr_start, swap_req, frame_sync;
  logic [8:0] wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic rd_valid, busy, swap_pending, bank_sel;
  logic s_wr_en, s_rd_en, s_clr_start, s_swap_req, s_frame_sync;
  logic [3:0] s_wr_addr, s_rd_addr;
  logic [15:0] s_wr_data, s_rd_data;
  logic s_rd_valid, s_busy, s_swap_pending, s_bank_sel;
  int vectors = 0;
  int errs = 0;
  int n;

  always #5 clk = ~clk;

  pic_buffer u0 (
    .sys_clk(clk), .sys_rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .busy(busy), .swap_req(swap_req), .frame_sync(frame_sync),
    .swap_pending(swap_pending), .bank_sel(bank_sel)
  );

  pic_buffer #(.ADDR_W(4), .NUM_BANKS(1)) u1 (
    .sys_clk(clk), .sys_rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .clr_start(s_clr_start), .busy(s_busy), .swap_req(s_swap_req), .frame_sync(s_frame_sync),
    .swap_pending(s_swap_pending), .bank_sel(s_bank_sel)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    {wr_en, rd_en, clr_start, swap_req, frame_sync} = '0;
    {s_wr_en, s_rd_en, s_clr_start, s_swap_req, s_frame_sync} = '0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    s_wr_addr = '0; s_rd_addr = '0; s_wr_data = '0;
    tick; tick;
    rst = 1'b0;
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", swap_pending, 0);
    check("rst_bank_sel", bank_sel, 0);

    // single bank: read-first on same-address collision
    s_wr_en = 1; s_wr_addr = 7; s_wr_data = 16'hAAAA; tick;
    s_rd_en = 1; s_rd_addr = 7; s_wr_data = 16'h1234; tick;
    check("sb_old_data", s_rd_data, 16'hAAAA);
    check("sb_valid", s_rd_valid, 1);
    s_wr_en = 0; tick;
    check("sb_new_data", s_rd_data, 16'h1234);
    s_rd_en = 0; s_swap_req = 1; tick;
    check("sb_pending_const", s_swap_pending, 0);
    s_swap_req = 0; s_frame_sync = 1; tick;
    s_frame_sync = 0;
    check("sb_bank_const", s_bank_sel, 0);

    // write bank 1, swap, read back
    wr_en = 1; wr_addr = 5; wr_data = 16'hB93C; tick;
    wr_en = 0; swap_req = 1; tick;
    swap_req = 0;
    check("swap_pending_set", swap_pending, 1);
    check("bank_before_sync", bank_sel, 0);
    frame_sync = 1; tick;
    frame_sync = 0;
    check("bank_after_sync", bank_sel, 1);
    check("pending_cleared", swap_pending, 0);
    rd_en = 1; rd_addr = 5; tick;
    rd_en = 0;
    check("rd_valid_n1", rd_valid, 1);
    check("rd_data_b93c", rd_data, 16'hB93C);
    tick;
    check("rd_valid_drop", rd_valid, 0);
    check("rd_data_hold", rd_data, 16'hB93C);

    // clear bank 0 with wr_en, clr_start, swap and reads hammering it
    clr_start = 1; tick;
    clr_start = 0;
    check("busy_start", busy, 1);
    n = 0;
    while (busy && n < 600) begin
      wr_en = 1; wr_addr = 9'(n); wr_data = 16'hFFFF;
      swap_req = (n == 10);
      frame_sync = (n == 20);
      clr_start = (n == 30);
      rd_en = (n == 40); rd_addr = 5;
      tick;
      n++;
      if (n == 41) check("rd_during_fill", rd_data, 16'hB93C);
    end
    {wr_en, swap_req, frame_sync, clr_start, rd_en} = '0;
    check("busy_cycles", n, 512);
    check("busy_end", busy, 0);
    check("bank_held_fill", bank_sel, 1);
    check("pending_held_fill", swap_pending, 1);
    frame_sync = 1; tick;
    frame_sync = 0;
    check("bank_after_fill", bank_sel, 0);
    check("pending_after_fill", swap_pending, 0);
    for (int i = 0; i < 512; i++) begin
      rd_en = 1; rd_addr = 9'(i); tick;
      check($sformatf("clr_rd_%0d", i), rd_data, 0);
    end
    rd_en = 0;

    // swap_req merged with executing frame_sync; reads use pre-swap bank
    swap_req = 1; tick;
    frame_sync = 1; rd_en = 1; rd_addr = 5; tick;
    check("coinc_bank", bank_sel, 1);
    check("coinc_pending", swap_pending, 1);
    check("coinc_rd_preswap", rd_data, 0);
    swap_req = 0; tick;
    frame_sync = 0; rd_en = 0;
    check("second_bank", bank_sel, 0);
    check("second_pending", swap_pending, 0);
    check("second_rd_preswap", rd_data, 16'hB93C);

    // reset mid-fill of bank 1
    for (int i = 0; i < 512; i++) begin
      wr_en = 1; wr_addr = 9'(i); wr_data = 16'(i + 'h100); tick;
    end
    wr_en = 0;
    clr_start = 1; tick;
    clr_start = 0;
    repeat (100) tick;
    rst = 1; wr_en = 1; wr_addr = 200; wr_data = 16'hDEAD; clr_start = 1; tick;
    rst = 0; wr_en = 0; clr_start = 0;
    check("abort_busy", busy, 0);
    check("abort_rd_valid", rd_valid, 0);
    swap_req = 1; tick;
    swap_req = 0; frame_sync = 1; tick;
    frame_sync = 0;
    check("abort_bank", bank_sel, 1);
    for (int i = 0; i < 512; i++) begin
      rd_en = 1; rd_addr = 9'(i); tick;
      check($sformatf("abort_rd_%0d", i), rd_data, (i < 100) ? 0 : 16'(i + 'h100));
    end
    rd_en = 0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
